mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu.sv | 173 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Load/store unit for the MEM stage. Accepts one aligned load or store from
// EX, builds byte lanes and enables, then holds a single request on the
// memory bus until mem_ack or until the wait-cycle budget runs out.
//
// Ports:
//   LSU_clk, LSU_rst            clock, asynchronous active-high reset
//   valid_E, ld_E, st_E         EX-stage instruction qualifiers
//   byte_E .. half_wordU_E      one-hot access size flags
//   ALU_out_E, rs2_data_E       effective address and store data
//   flush_i                     kill the in-flight access result
//   mem_req/we/addr/wdata/be    memory request channel (held while waiting)
//   mem_ack, mem_rdata          memory completion and raw read word
//   mem_read_data_M             last completed load word (raw)
//   mem_access_addr_1_0_bits_M  low address bits of the last accepted access
//   stall_o                     upstream pipeline hold
//   done_o, misalign_o, bus_err_o  one-cycle status pulses
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        LSU_clk,
  input  logic        LSU_rst,
  input  logic        valid_E,
  input  logic        ld_E,
  input  logic        st_E,
  input  logic        byte_E,
  input  logic        half_word_E,
  input  logic        full_word_E,
  input  logic        byteU_E,
  input  logic        half_wordU_E,
  input  logic [31:0] ALU_out_E,
  input  logic [31:0] rs2_data_E,
  input  logic        flush_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_read_data_M,
  output logic [1:0]  mem_access_addr_1_0_bits_M,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               kill_reg;
  logic               we_reg;
  logic               ld_reg;
  logic               done_reg;
  logic               bus_err_reg;

  logic               is_mem, is_byte, is_half, is_word;
  logic               misaligned, accept, misalign_hit;
  logic               cnt_hit, timeout, ack_done, kill_now;
  logic [3:0]         be_next;
  logic [31:0]        wdata_next;

  assign is_mem  = valid_E & (ld_E | st_E);
  assign is_byte = byte_E | byteU_E;
  assign is_half = half_word_E | half_wordU_E;
  assign is_word = full_word_E;

  assign misaligned = (is_half & ALU_out_E[0]) | (is_word & (|ALU_out_E[1:0]));

  // Reset gates the combinational decode so that every output reads 0 while
  // LSU_rst is high, even if EX keeps presenting an access.
  assign accept       = ~LSU_rst & (state_reg == S_IDLE) & is_mem & ~flush_i & ~misaligned;
  assign misalign_hit = ~LSU_rst & (state_reg == S_IDLE) & is_mem & ~flush_i &  misaligned;

  // The timeout fires on the WAIT cycle whose edge would bring the counter
  // to TIMEOUT_CYCLES; an ack in that same cycle wins.
  assign cnt_hit  = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ack_done = (state_reg == S_WAIT) & mem_ack;
  assign timeout  = (state_reg == S_WAIT) & ~mem_ack & cnt_hit;
  // A flush arriving together with the ack still kills the result.
  assign kill_now = kill_reg | flush_i;

  // Store lane generation; loads read the whole word.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    if (st_E) begin
      if (is_byte) begin
        be_next    = 4'b0001 << ALU_out_E[1:0];
        wdata_next = {4{rs2_data_E[7:0]}};
      end else if (is_half) begin
        be_next    = ALU_out_E[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{rs2_data_E[15:0]}};
      end else begin
        be_next    = 4'b1111;
        wdata_next = rs2_data_E;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge LSU_clk or posedge LSU_rst) begin
    if (LSU_rst) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_WAIT;
      S_WAIT:  if (mem_ack || timeout) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_req    = (state_reg == S_WAIT);
    mem_we     = (state_reg == S_WAIT) & we_reg;
    stall_o    = accept | ((state_reg == S_WAIT) & ~mem_ack);
    misalign_o = misalign_hit;
  end

  assign done_o    = done_reg;
  assign bus_err_o = bus_err_reg;

  // Request latch, wait counter, kill flag and result registers.
  always_ff @(posedge LSU_clk or posedge LSU_rst) begin
    if (LSU_rst) begin
      mem_addr                   <= '0;
      mem_wdata                  <= '0;
      mem_be                     <= '0;
      we_reg                     <= 1'b0;
      ld_reg                     <= 1'b0;
      cnt_reg                    <= '0;
      kill_reg                   <= 1'b0;
      mem_read_data_M            <= '0;
      mem_access_addr_1_0_bits_M <= '0;
      done_reg                   <= 1'b0;
      bus_err_reg                <= 1'b0;
    end else begin
      done_reg    <= ack_done & ~kill_now;
      bus_err_reg <= timeout;
      if (accept) begin
        mem_addr                   <= ALU_out_E[31:2];
        mem_wdata                  <= wdata_next;
        mem_be                     <= be_next;
        we_reg                     <= st_E;
        ld_reg                     <= ld_E;
        mem_access_addr_1_0_bits_M <= ALU_out_E[1:0];
        cnt_reg                    <= '0;
        kill_reg                   <= 1'b0;
      end else if (state_reg == S_WAIT) begin
        if (mem_ack) begin
          if (ld_reg && !kill_now) mem_read_data_M <= mem_rdata;
          kill_reg <= 1'b0;
        end else if (timeout) begin
          kill_reg <= 1'b0;
        end else if (flush_i) begin
          kill_reg <= 1'b1;
        end
        if (!mem_ack && cnt_reg != CNT_W'(TIMEOUT_CYCLES))
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu (TIMEOUT_CYCLES = 4).
module tb_mem_stage_lsu;

  logic        LSU_clk;
  logic        LSU_rst;
  logic        valid_E, ld_E, st_E;
  logic        byte_E, half_word_E, full_word_E, byteU_E, half_wordU_E;
  logic [31:0] ALU_out_E, rs2_data_E;
  logic        flush_i;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] mem_read_data_M;
  logic [1:0]  mem_access_addr_1_0_bits_M;
  logic        stall_o, done_o, misalign_o, bus_err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .LSU_clk                    (LSU_clk),
    .LSU_rst                    (LSU_rst),
    .valid_E                    (valid_E),
    .ld_E                       (ld_E),
    .st_E                       (st_E),
    .byte_E                     (byte_E),
    .half_word_E                (half_word_E),
    .full_word_E                (full_word_E),
    .byteU_E                    (byteU_E),
    .half_wordU_E               (half_wordU_E),
    .ALU_out_E                  (ALU_out_E),
    .rs2_data_E                 (rs2_data_E),
    .flush_i                    (flush_i),
    .mem_req                    (mem_req),
    .mem_we                     (mem_we),
    .mem_addr                   (mem_addr),
    .mem_wdata                  (mem_wdata),
    .mem_be                     (mem_be),
    .mem_ack                    (mem_ack),
    .mem_rdata                  (mem_rdata),
    .mem_read_data_M            (mem_read_data_M),
    .mem_access_addr_1_0_bits_M (mem_access_addr_1_0_bits_M),
    .stall_o                    (stall_o),
    .done_o                     (done_o),
    .misalign_o                 (misalign_o),
    .bus_err_o                  (bus_err_o)
  );

  initial begin
    LSU_clk = 1'b0;
    forever #5 LSU_clk = ~LSU_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge LSU_clk);
    #1;
  endtask

  // Move to the falling edge (output sample point).
  task automatic sample();
    @(negedge LSU_clk);
  endtask

  // sz: 0 byte, 1 half, 2 word, 3 byteU, 4 halfU
  task automatic drive_op(input logic ld, input logic st, input int sz,
                          input logic [31:0] addr, input logic [31:0] data);
    valid_E      = 1'b1;
    ld_E         = ld;
    st_E         = st;
    byte_E       = (sz == 0);
    half_word_E  = (sz == 1);
    full_word_E  = (sz == 2);
    byteU_E      = (sz == 3);
    half_wordU_E = (sz == 4);
    ALU_out_E    = addr;
    rs2_data_E   = data;
  endtask

  task automatic clear_op();
    valid_E = 1'b0; ld_E = 1'b0; st_E = 1'b0;
    byte_E = 1'b0; half_word_E = 1'b0; full_word_E = 1'b0;
    byteU_E = 1'b0; half_wordU_E = 1'b0;
    ALU_out_E = 32'h0; rs2_data_E = 32'h0;
  endtask

  initial begin
    LSU_rst   = 1'b1;
    clear_op();
    flush_i   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Reset state
    #3;
    check("rst_req",    32'(mem_req), 32'h0);
    check("rst_stall",  32'(stall_o), 32'h0);
    check("rst_addr",   32'(mem_addr), 32'h0);
    check("rst_be",     32'(mem_be), 32'h0);
    check("rst_rdata",  mem_read_data_M, 32'h0);
    check("rst_pulses", {29'h0, done_o, misalign_o, bus_err_o}, 32'h0);
    tick(); tick();
    LSU_rst = 1'b0;

    // SB 0x1003, ack two cycles after the first mem_req
    tick(); drive_op(1'b0, 1'b1, 0, 32'h0000_1003, 32'h0000_00A5);
    sample(); check("sb_stall_c0", 32'(stall_o), 32'h1);
    check("sb_req_c0", 32'(mem_req), 32'h0);
    tick(); clear_op();
    sample(); check("sb_req", 32'(mem_req), 32'h1);
    check("sb_we",    32'(mem_we), 32'h1);
    check("sb_be",    32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_addr",  32'(mem_addr), 32'h400);
    check("sb_lo",    32'(mem_access_addr_1_0_bits_M), 32'h3);
    check("sb_stall_c1", 32'(stall_o), 32'h1);
    tick(); sample(); check("sb_stall_c2", 32'(stall_o), 32'h1);
    check("sb_hold_be", 32'(mem_be), 32'h8);
    tick(); mem_ack = 1'b1;
    sample(); check("sb_stall_ack", 32'(stall_o), 32'h0);
    check("sb_done_early", 32'(done_o), 32'h0);
    tick(); mem_ack = 1'b0;
    sample(); check("sb_done", 32'(done_o), 32'h1);
    check("sb_req_idle", 32'(mem_req), 32'h0);
    tick(); sample(); check("sb_done_once", 32'(done_o), 32'h0);
    $display("[TB] SB addr=0x1003 complete");

    // LW 0x2000, rdata DEADBEEF
    tick(); drive_op(1'b1, 1'b0, 2, 32'h0000_2000, 32'h0);
    tick(); clear_op();
    sample(); check("lw_req", 32'(mem_req), 32'h1);
    check("lw_we", 32'(mem_we), 32'h0);
    check("lw_be", 32'(mem_be), 32'hF);
    check("lw_lo", 32'(mem_access_addr_1_0_bits_M), 32'h0);
    check("lw_addr", 32'(mem_addr), 32'h800);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0;
    sample(); check("lw_rdata", mem_read_data_M, 32'hDEAD_BEEF);
    check("lw_done", 32'(done_o), 32'h1);
    $display("[TB] LW addr=0x2000 complete");

    // SH 0x1006 (upper half) and SHU 0x1004 (lower half), ack in first WAIT cycle
    tick(); drive_op(1'b0, 1'b1, 1, 32'h0000_1006, 32'h1234_BEEF);
    tick(); clear_op(); mem_ack = 1'b1;
    sample(); check("sh_be", 32'(mem_be), 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_lo", 32'(mem_access_addr_1_0_bits_M), 32'h2);
    check("sh_stall", 32'(stall_o), 32'h0);
    tick(); mem_ack = 1'b0;
    sample(); check("sh_done", 32'(done_o), 32'h1);
    check("sh_keep_rdata", mem_read_data_M, 32'hDEAD_BEEF);
    tick(); drive_op(1'b0, 1'b1, 4, 32'h0000_1004, 32'h0000_5A3C);
    tick(); clear_op(); mem_ack = 1'b1;
    sample(); check("shu_be", 32'(mem_be), 32'h3);
    check("shu_wdata", mem_wdata, 32'h5A3C_5A3C);
    tick(); mem_ack = 1'b0;
    $display("[TB] SH addr=0x1006 / 0x1004 complete");

    // Misaligned LH 0x2001 and SW 0x2002
    tick(); drive_op(1'b1, 1'b0, 1, 32'h0000_2001, 32'h0);
    sample(); check("lh_mis", 32'(misalign_o), 32'h1);
    check("lh_stall", 32'(stall_o), 32'h0);
    check("lh_req", 32'(mem_req), 32'h0);
    tick(); drive_op(1'b0, 1'b1, 2, 32'h0000_2002, 32'h0);
    sample(); check("sw_mis", 32'(misalign_o), 32'h1);
    tick(); clear_op();
    sample(); check("mis_clear", 32'(misalign_o), 32'h0);
    check("mis_req", 32'(mem_req), 32'h0);
    $display("[TB] misaligned LH 0x2001 / SW 0x2002 rejected");

    // LW 0x3000 flushed in WAIT, ack three cycles later
    tick(); drive_op(1'b1, 1'b0, 2, 32'h0000_3000, 32'h0);
    tick(); clear_op(); flush_i = 1'b1;
    sample(); check("fl_req", 32'(mem_req), 32'h1);
    tick(); flush_i = 1'b0;
    tick();
    tick(); mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0;
    sample(); check("fl_done", 32'(done_o), 32'h0);
    check("fl_rdata", mem_read_data_M, 32'hDEAD_BEEF);
    check("fl_idle", 32'(mem_req), 32'h0);
    $display("[TB] flushed LW addr=0x3000 drained");

    // Timeout: no ack for four WAIT cycles
    tick(); drive_op(1'b1, 1'b0, 2, 32'h0000_4000, 32'h0);
    tick(); clear_op();
    tick(); tick(); tick();
    sample(); check("to_w4_req", 32'(mem_req), 32'h1);
    check("to_w4_err", 32'(bus_err_o), 32'h0);
    tick(); sample(); check("to_err", 32'(bus_err_o), 32'h1);
    check("to_req", 32'(mem_req), 32'h0);
    check("to_stall", 32'(stall_o), 32'h0);
    tick(); sample(); check("to_err_once", 32'(bus_err_o), 32'h0);
    $display("[TB] timeout LW addr=0x4000 bus error");

    // Ack on the same cycle the counter would expire: ack wins
    tick(); drive_op(1'b1, 1'b0, 2, 32'h0000_4004, 32'h0);
    tick(); clear_op();
    tick(); tick(); tick(); mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0;
    sample(); check("ackto_err", 32'(bus_err_o), 32'h0);
    check("ackto_done", 32'(done_o), 32'h1);
    check("ackto_rdata", mem_read_data_M, 32'hCAFE_F00D);
    $display("[TB] LW addr=0x4004 acked at timeout boundary");

    // Flush in IDLE blocks acceptance; ack in IDLE is ignored
    tick(); drive_op(1'b0, 1'b1, 2, 32'h0000_5000, 32'h0);
    flush_i = 1'b1;
    sample(); check("fli_stall", 32'(stall_o), 32'h0);
    tick(); clear_op(); flush_i = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    sample(); check("fli_req", 32'(mem_req), 32'h0);
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0;
    sample(); check("idle_ack_done", 32'(done_o), 32'h0);
    check("idle_ack_rdata", mem_read_data_M, 32'hCAFE_F00D);
    $display("[TB] flush/ack in IDLE ignored");

    // Reset asserted mid-WAIT, checked before any clock edge
    tick(); drive_op(1'b0, 1'b1, 2, 32'h0000_5004, 32'h1122_3344);
    tick(); clear_op();
    sample(); check("rw_req_pre", 32'(mem_req), 32'h1);
    #1 LSU_rst = 1'b1;
    #1;
    check("rw_req",   32'(mem_req), 32'h0);
    check("rw_we",    32'(mem_we), 32'h0);
    check("rw_stall", 32'(stall_o), 32'h0);
    check("rw_addr",  32'(mem_addr), 32'h0);
    check("rw_wdata", mem_wdata, 32'h0);
    check("rw_be",    32'(mem_be), 32'h0);
    check("rw_rdata", mem_read_data_M, 32'h0);
    tick(); tick(); LSU_rst = 1'b0;
    tick(); sample(); check("rw_done", 32'(done_o), 32'h0);
    check("rw_req_post", 32'(mem_req), 32'h0);
    $display("[TB] reset during WAIT abandoned SW addr=0x5004");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
